// File: rtl/hazard_ctrl.sv
// Hazard control: detects load-use and branch-operand hazards.
// Drives per-stage write enables, NOP flushes and a stall counter.
//
// Ports:
//   clk, rst             clock, async active-high reset
//   IF_ID_inst_opcode    opcode of the instruction in ID
//   IF_ID_rs1/rs2        ID source register addresses
//   ID_EX_reg_wr_en      EX instruction writes a register
//   ID_EX_mem_rd_en      EX instruction is a load
//   ID_EX_rd             EX destination register
//   EX_MEM_mem_rd_en     MEM instruction is a load
//   EX_MEM_rd            MEM destination register
//   branch_taken         branch in ID resolved taken
//   dmem_busy            data memory not ready this cycle
//   stall_cnt_clr        synchronous clear of stall_cnt
//   pc_wr_en .. EX_MEM_wr_en   per-stage register enables
//   IF_ID_flush, ID_EX_flush   insert a NOP into that register
//   stall_cnt            saturating count of cycles with pc_wr_en=0
//   hz_state             current FSM state (RUN/HOLD/MEM_WAIT)
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                IF_ID_inst_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
    input  logic                      ID_EX_reg_wr_en,
    input  logic                      ID_EX_mem_rd_en,
    input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
    input  logic                      EX_MEM_mem_rd_en,
    input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
    input  logic                      branch_taken,
    input  logic                      dmem_busy,
    input  logic                      stall_cnt_clr,
    output logic                      pc_wr_en,
    output logic                      IF_ID_wr_en,
    output logic                      ID_EX_wr_en,
    output logic                      EX_MEM_wr_en,
    output logic                      IF_ID_flush,
    output logic                      ID_EX_flush,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [1:0]                hz_state
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        HOLD     = 2'b01,
        MEM_WAIT = 2'b10
    } hz_state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    hz_state_t state;
    hz_state_t state_nxt;
    hz_state_t eff;
    logic      ret_hold;
    logic      ret_hold_nxt;

    logic use_rs1;
    logic use_rs2;
    logic is_branch;
    logic hit_ex;
    logic hit_mem;
    logic load_use;
    logic br_alu;
    logic br_ld_ex;
    logic br_ld_mem;
    logic stall;

    assign use_rs1 = !(IF_ID_inst_opcode == OP_LUI   ||
                       IF_ID_inst_opcode == OP_AUIPC ||
                       IF_ID_inst_opcode == OP_JAL);
    assign use_rs2 = (IF_ID_inst_opcode == OP_REG   ||
                      IF_ID_inst_opcode == OP_STORE ||
                      IF_ID_inst_opcode == OP_BRANCH);
    assign is_branch = (IF_ID_inst_opcode == OP_BRANCH);

    // x0 is never a real producer, so rd==0 never matches
    assign hit_ex = (ID_EX_rd != '0) &&
                    ((use_rs1 && IF_ID_rs1 == ID_EX_rd) ||
                     (use_rs2 && IF_ID_rs2 == ID_EX_rd));
    assign hit_mem = (EX_MEM_rd != '0) &&
                     ((use_rs1 && IF_ID_rs1 == EX_MEM_rd) ||
                      (use_rs2 && IF_ID_rs2 == EX_MEM_rd));

    assign load_use  = ID_EX_mem_rd_en && hit_ex;
    assign br_alu    = is_branch && ID_EX_reg_wr_en &&
                       !ID_EX_mem_rd_en && hit_ex;
    assign br_ld_ex  = is_branch && load_use;
    assign br_ld_mem = is_branch && EX_MEM_mem_rd_en && hit_mem;
    assign stall     = load_use || br_alu || br_ld_ex || br_ld_mem;

    assign hz_state = state;

    always_comb begin
        pc_wr_en     = 1'b0;
        IF_ID_wr_en  = 1'b0;
        ID_EX_wr_en  = 1'b0;
        EX_MEM_wr_en = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        state_nxt    = RUN;
        ret_hold_nxt = ret_hold;
        eff          = RUN;

        if (dmem_busy) begin
            // Freeze everything; remember an interrupted HOLD
            state_nxt    = MEM_WAIT;
            ret_hold_nxt = ret_hold || (state == HOLD);
        end else begin
            case (state)
                RUN:      eff = RUN;
                HOLD:     eff = HOLD;
                MEM_WAIT: eff = ret_hold ? HOLD : RUN;
                default:  eff = RUN;
            endcase

            if (state == MEM_WAIT)
                ret_hold_nxt = 1'b0;

            if (eff == HOLD || stall) begin
                pc_wr_en     = 1'b0;
                IF_ID_wr_en  = 1'b0;
                ID_EX_wr_en  = 1'b1;
                EX_MEM_wr_en = 1'b1;
                ID_EX_flush  = 1'b1;
            end else begin
                pc_wr_en     = 1'b1;
                IF_ID_wr_en  = 1'b1;
                ID_EX_wr_en  = 1'b1;
                EX_MEM_wr_en = 1'b1;
                IF_ID_flush  = branch_taken;
            end

            // Leaving MEM_WAIT lands in the target state itself
            if (state == MEM_WAIT)
                state_nxt = eff;
            else if (eff == RUN && br_ld_ex)
                state_nxt = HOLD;
            else
                state_nxt = RUN;
        end

        if (rst) begin
            pc_wr_en     = 1'b0;
            IF_ID_wr_en  = 1'b0;
            ID_EX_wr_en  = 1'b0;
            EX_MEM_wr_en = 1'b0;
            IF_ID_flush  = 1'b0;
            ID_EX_flush  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            ret_hold <= 1'b0;
        end else begin
            state    <= state_nxt;
            ret_hold <= ret_hold_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall_cnt_clr)
            stall_cnt <= '0;
        else if (!pc_wr_en && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with
// literal expectations, then randomized traffic against a model.
module tb_hazard_ctrl;

    localparam int RW   = 5;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    op;
    logic [RW-1:0] rs1, rs2, ex_rd, mem_rd;
    logic          ex_wr, ex_ld, mem_ld, bt, busy, clr;
    logic          pc_we, ifid_we, idex_we, exmem_we, ifid_fl, idex_fl;
    logic [CW-1:0] cnt;
    logic [1:0]    hz;

    hazard_ctrl #(.REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .IF_ID_inst_opcode(op),
        .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
        .ID_EX_reg_wr_en(ex_wr), .ID_EX_mem_rd_en(ex_ld),
        .ID_EX_rd(ex_rd),
        .EX_MEM_mem_rd_en(mem_ld), .EX_MEM_rd(mem_rd),
        .branch_taken(bt), .dmem_busy(busy),
        .stall_cnt_clr(clr),
        .pc_wr_en(pc_we), .IF_ID_wr_en(ifid_we),
        .ID_EX_wr_en(idex_we), .EX_MEM_wr_en(exmem_we),
        .IF_ID_flush(ifid_fl), .ID_EX_flush(idex_fl),
        .stall_cnt(cnt), .hz_state(hz)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model status: 0 running, 1 forced extra stall, 2 waiting on memory
    int m_st  = 0;
    bit m_ret = 0;
    int m_cnt = 0;

    // {pc, if_id, id_ex, ex_mem, if_id_flush, id_ex_flush}
    localparam logic [5:0] STALL_OUT = 6'b001101;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic bit hits(logic [RW-1:0] rd);
        bit u1, u2;
        u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6f);
        u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
        return rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    endfunction

    // One clock cycle: compare outputs against model, then advance model
    task automatic cycle();
        logic [5:0] e_out;
        int  nst, tgt;
        bit  nret, br, lu, bralu, brldex, brldmem, stl;
        #1;
        if (rst) begin
            m_st = 0; m_ret = 0; m_cnt = 0;
        end
        br      = (op == 7'h63);
        lu      = ex_ld && hits(ex_rd);
        bralu   = br && ex_wr && !ex_ld && hits(ex_rd);
        brldex  = br && lu;
        brldmem = br && mem_ld && hits(mem_rd);
        stl     = lu || bralu || brldex || brldmem;
        nret    = m_ret;
        if (rst) begin
            e_out = '0; nst = 0;
        end else if (busy) begin
            e_out = '0; nst = 2;
            if (m_st == 1) nret = 1;
        end else begin
            tgt = (m_st == 2) ? (m_ret ? 1 : 0) : m_st;
            if (m_st == 2) nret = 0;
            if (tgt == 1 || stl) e_out = STALL_OUT;
            else e_out = {4'b1111, bt, 1'b0};
            if (m_st == 2) nst = tgt;
            else if (tgt == 0 && brldex) nst = 1;
            else nst = 0;
        end
        chk("outputs", {pc_we, ifid_we, idex_we, exmem_we,
                        ifid_fl, idex_fl}, e_out);
        chk("hz_state", hz, m_st);
        chk("stall_cnt", cnt, m_cnt);
        @(posedge clk);
        if (rst) begin
            m_st = 0; m_ret = 0; m_cnt = 0;
        end else begin
            if (clr) m_cnt = 0;
            else if (!e_out[5] && m_cnt < CMAX) m_cnt = m_cnt + 1;
            m_st  = nst;
            m_ret = nret;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        op = 7'h13; rs1 = 1; rs2 = 2;
        ex_wr = 0; ex_ld = 0; ex_rd = 0;
        mem_ld = 0; mem_rd = 0;
        bt = 0; busy = 0; clr = 0;
    endtask

    task automatic clear_cnt();
        idle(); clr = 1; cycle(); clr = 0;
    endtask

    initial begin
        rst = 1; idle();
        @(negedge clk); #1;
        chk("rst_pc", pc_we, 0);
        chk("rst_exmem", exmem_we, 0);
        chk("rst_idexfl", idex_fl, 0);
        chk("rst_hz", hz, 0);
        chk("rst_cnt", cnt, 0);
        cycle();
        rst = 0;
        clear_cnt();

        // Load x5 in EX, add uses x5 as rs2
        op = 7'h33; rs1 = 1; rs2 = 5; ex_ld = 1; ex_wr = 1; ex_rd = 5;
        #1; chk("lu_pc", pc_we, 0); chk("lu_flush", idex_fl, 1);
        cycle();
        ex_ld = 0; ex_wr = 0; ex_rd = 0;
        #1; chk("lu_after_pc", pc_we, 1); chk("lu_cnt", cnt, 1);
        cycle();

        // Load x7 in EX, beq reads x7: two stalls
        clear_cnt();
        op = 7'h63; rs1 = 7; rs2 = 0; ex_ld = 1; ex_wr = 1; ex_rd = 7;
        #1; chk("bl_hz0", hz, 0); chk("bl_pc0", pc_we, 0);
        cycle();
        ex_ld = 0; ex_wr = 0; ex_rd = 0; mem_ld = 1; mem_rd = 7;
        #1; chk("bl_hz1", hz, 1); chk("bl_pc1", pc_we, 0);
        cycle();
        mem_ld = 0; mem_rd = 0;
        #1; chk("bl_hz2", hz, 0); chk("bl_pc2", pc_we, 1);
        chk("bl_cnt", cnt, 2);
        cycle();

        // ALU write x3, beq reads x3, taken
        idle();
        op = 7'h63; rs1 = 3; rs2 = 0; ex_wr = 1; ex_rd = 3; bt = 1;
        #1; chk("ba_pc", pc_we, 0); chk("ba_iffl0", ifid_fl, 0);
        cycle();
        ex_wr = 0; ex_rd = 0;
        #1; chk("ba_iffl1", ifid_fl, 1); chk("ba_pc1", pc_we, 1);
        cycle();

        // dmem_busy for 3 cycles during HOLD
        idle();
        op = 7'h63; rs1 = 7; rs2 = 0; ex_ld = 1; ex_wr = 1; ex_rd = 7;
        cycle();
        ex_ld = 0; ex_wr = 0; ex_rd = 0; busy = 1;
        #1; chk("mw_hz_a", hz, 1);
        chk("mw_en_a", {pc_we, ifid_we, idex_we, exmem_we}, 0);
        cycle();
        #1; chk("mw_hz_b", hz, 2);
        chk("mw_en_b", {pc_we, ifid_we, idex_we, exmem_we}, 0);
        cycle();
        #1; chk("mw_hz_c", hz, 2);
        chk("mw_en_c", {pc_we, ifid_we, idex_we, exmem_we}, 0);
        cycle();
        busy = 0;
        #1; chk("mw_exit_idex", idex_we, 1); chk("mw_exit_pc", pc_we, 0);
        cycle();
        #1; chk("mw_hold_hz", hz, 1); chk("mw_hold_pc", pc_we, 0);
        cycle();
        #1; chk("mw_run_hz", hz, 0); chk("mw_run_pc", pc_we, 1);
        cycle();

        // Writer rd=0, lui with rs1 field 0
        idle();
        op = 7'h37; rs1 = 0; rs2 = 0; ex_ld = 1; ex_wr = 1; ex_rd = 0;
        #1; chk("x0_pc", pc_we, 1);
        cycle();

        // Saturation and clear-during-stall
        clear_cnt();
        busy = 1;
        for (int i = 0; i < CMAX + 5; i++) cycle();
        #1; chk("sat_cnt", cnt, CMAX);
        clr = 1;
        cycle();
        #1; chk("clr_cnt", cnt, 0);
        clr = 0;

        // Reset in the middle of MEM_WAIT
        cycle();
        #1; chk("rw_hz_pre", hz, 2);
        rst = 1;
        #1; chk("rw_hz", hz, 0); chk("rw_cnt", cnt, 0);
        cycle();
        rst = 0; busy = 0;
        cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] ops [8];
            ops = '{7'h33, 7'h23, 7'h63, 7'h03,
                    7'h13, 7'h37, 7'h17, 7'h6f};
            op     = ops[$urandom_range(0, 7)];
            rs1    = RW'($urandom_range(0, 7));
            rs2    = RW'($urandom_range(0, 7));
            ex_rd  = RW'($urandom_range(0, 7));
            mem_rd = RW'($urandom_range(0, 7));
            ex_wr  = 1'($urandom_range(0, 1));
            ex_ld  = ($urandom_range(0, 2) == 0);
            mem_ld = ($urandom_range(0, 2) == 0);
            bt     = ($urandom_range(0, 2) == 0);
            busy   = ($urandom_range(0, 6) == 0);
            clr    = ($urandom_range(0, 40) == 0);
            rst    = ($urandom_range(0, 80) == 0);
            cycle();
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_WIDTH, default 5, the register-address width.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, the stall-counter width.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  the reset; asynchronous, active-high.
REQ-005 SHALL have port IF_ID_inst_opcode  in  7  the opcode of the instruction in ID.
REQ-006 SHALL have ports IF_ID_rs1 and IF_ID_rs2  in  REG_ADDR_WIDTH  the ID source registers.
REQ-007 SHALL have ports ID_EX_reg_wr_en and ID_EX_mem_rd_en  in  1  the EX-stage writes-reg and is-load flags; ID_EX_rd  in  REG_ADDR_WIDTH.
REQ-008 SHALL have port EX_MEM_mem_rd_en  in  1  the MEM-stage is-load flag; EX_MEM_rd  in  REG_ADDR_WIDTH.
REQ-009 SHALL have port branch_taken  in  1  the branch-resolved-taken flag from ID.
REQ-010 SHALL have port dmem_busy  in  1  data memory not ready this cycle.
REQ-011 SHALL have port stall_cnt_clr  in  1  synchronous clear of stall_cnt.
REQ-012 SHALL have ports pc_wr_en, IF_ID_wr_en, ID_EX_wr_en, EX_MEM_wr_en  out  1  per-stage register enables.
REQ-013 SHALL have ports IF_ID_flush, ID_EX_flush  out  1  insert a NOP into the named register.
REQ-014 SHALL have port stall_cnt  out  CNT_WIDTH  count of cycles with pc_wr_en=0; hz_state  out  2  current FSM state.

Function
REQ-015 SHALL decode use_rs1 = opcode not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL}, and use_rs2 = opcode in {0110011, 0100011, 1100011}.
REQ-016 SHALL treat a source as matching only when it is used, equals the producer's rd, and that rd is non-zero.
REQ-017 SHALL define load_use = ID_EX_mem_rd_en and an ID source matching ID_EX_rd.
REQ-018 SHALL define br_alu = (opcode == 1100011), ID_EX_reg_wr_en, !ID_EX_mem_rd_en and a source matching ID_EX_rd; that is a 1-cycle stall.
REQ-019 SHALL define br_ld_ex = branch and load_use; that is a 2-cycle stall.
REQ-020 SHALL define br_ld_mem = branch, EX_MEM_mem_rd_en and a source matching EX_MEM_rd; that is a 1-cycle stall.
REQ-021 SHALL implement the FSM states RUN=00, HOLD=01 and MEM_WAIT=10, reported on hz_state; encoding 11 is unreachable and SHALL recover to RUN.
REQ-022 SHALL compute outputs combinationally from the state and the inputs, and register only the next state.
REQ-023 In any state with dmem_busy=1, SHALL freeze: all four wr_en=0, both flushes=0, next state MEM_WAIT; it SHALL set ret_hold=1 if the current state is HOLD.
REQ-024 In MEM_WAIT with dmem_busy=0, SHALL go to HOLD if ret_hold, else to RUN; ret_hold SHALL clear on exit; this cycle's outputs SHALL follow the target state's rules.
REQ-025 In RUN with a stall condition (load_use, br_alu, br_ld_ex or br_ld_mem) SHALL drive pc_wr_en=0, IF_ID_wr_en=0, ID_EX_flush=1, ID_EX_wr_en=1, EX_MEM_wr_en=1 and IF_ID_flush=0.
REQ-026 In RUN, next state SHALL be HOLD when br_ld_ex, else RUN.
REQ-027 In HOLD, SHALL stall unconditionally using the REQ-025 outputs, then return to RUN.
REQ-028 In RUN with no stall, all wr_en SHALL be 1 and ID_EX_flush=0.
REQ-029 In RUN with no stall, IF_ID_flush SHALL equal branch_taken (1-cycle pulse per taken branch).
REQ-030 branch_taken SHALL be ignored during any stall or freeze cycle.
REQ-031 Priority SHALL be dmem_busy > HOLD > stall > branch_taken flush.
REQ-032 stall_cnt SHALL increment by 1 on each clock edge where pc_wr_en=0, and SHALL saturate at all-ones with no wrap.
REQ-033 stall_cnt_clr SHALL zero stall_cnt at the next edge, and SHALL win over a simultaneous increment.

Reset
REQ-034 While rst=1: state=RUN, ret_hold=0, stall_cnt=0, all wr_en=0, both flushes=0, hz_state=00.
REQ-035 Assertion of rst mid-stall or mid-MEM_WAIT SHALL abort the sequence immediately.
REQ-036 After rst deasserts, the first edge SHALL evaluate from RUN.

Verification
REQ-037 Load x5 in EX, ID add uses x5 as rs2 -> one cycle pc_wr_en=0 and ID_EX_flush=1, then normal flow; stall_cnt=1.
REQ-038 Load x7 in EX, ID beq reads x7 -> two stall cycles (hz_state 00 then 01), then 00; stall_cnt=2.
REQ-039 ALU write x3 in EX, ID beq reads x3, branch_taken=1 -> one stall with IF_ID_flush=0, next cycle IF_ID_flush=1.
REQ-040 dmem_busy high for 3 cycles during HOLD -> all enables 0 for 3 cycles, hz_state=10, then one HOLD cycle, then RUN.
REQ-041 Writer rd=0, ID lui with rs1 field = 0 -> no stall.
REQ-042 stall_cnt preloaded to 0xFFFF with a stall -> it stays at 0xFFFF.
REQ-043 stall_cnt_clr during a stall -> stall_cnt = 0.
REQ-044 rst pulsed mid-MEM_WAIT -> hz_state=00, stall_cnt=0.
